// File: rtl/dense_layer_sequencer.sv
// Walks SDRAM layer descriptors and drives the dense controller layer by layer.
// Optional SEQ_CYCLE_COUNT_EN adds a saturating busy-cycle counter on register 4.
module dense_layer_sequencer #(
  parameter int unsigned LAYER_W     = 12,
  parameter int unsigned DESC_STRIDE = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        slave_waitrequest,
  input  logic [2:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        mem_waitrequest,
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic [31:0] mem_readdata,
  input  logic        acc_waitrequest,
  output logic [2:0]  acc_address,
  output logic        acc_read,
  input  logic [31:0] acc_readdata,
  output logic        acc_write,
  output logic [31:0] acc_writedata
);

  localparam int unsigned DESC_WORDS = 5;
  localparam int unsigned K_W        = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CHECK, S_PROGRAM, S_START, S_WAITDONE, S_NEXT
  } state_t;

  state_t               state_q, state_d;
  logic [K_W-1:0]       k_q, k_d;
  logic                 gap_q, gap_d;
  logic [LAYER_W-1:0]   cur_layer_q, cur_layer_d;
  logic [LAYER_W-1:0]   num_layers_q;
  logic [31:0]          desc_base_q;
  logic [31:0]          desc_q [DESC_WORDS];
  logic                 done_q, done_d, err_q, err_d;
  logic                 desc_wr;
  logic                 busy;
  logic                 start_req;
  logic                 mem_xfer, acc_xfer;
  logic [31:0]          layer_addr;
  logic                 mem_read_d, acc_write_d, acc_read_d;
  logic [31:0]          mem_address_d, acc_writedata_d;
  logic [2:0]           acc_address_d;
  logic [31:0]          cycles_rd;
  logic                 unused_ok;

  assign slave_waitrequest = 1'b0;
  assign busy      = (state_q != S_IDLE);
  assign start_req = slave_write && (slave_address == 3'd0);
  assign mem_xfer  = mem_read && !mem_waitrequest;
  assign acc_xfer  = (acc_write || acc_read) && !acc_waitrequest;
  assign unused_ok = ^acc_readdata;

  // Next-state and next-output logic; gap forces one strobe-free cycle after every transfer
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    gap_d       = 1'b0;
    cur_layer_d = cur_layer_q;
    done_d      = done_q;
    err_d       = err_q;
    desc_wr     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_req) begin
          done_d      = 1'b0;
          err_d       = 1'b0;
          cur_layer_d = '0;
          k_d         = '0;
          if (num_layers_q == '0) done_d = 1'b1;
          else                    state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (mem_xfer) begin
          desc_wr = 1'b1;
          gap_d   = 1'b1;
          if (k_q == K_W'(4)) state_d = S_CHECK;
          else                k_d = k_q + K_W'(1);
        end
      end
      S_CHECK: begin
        k_d = '0;
        if (desc_q[4] == '0) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_PROGRAM;
        end
      end
      S_PROGRAM: begin
        if (acc_xfer) begin
          gap_d = 1'b1;
          if (k_q == K_W'(4)) state_d = S_START;
          else                k_d = k_q + K_W'(1);
        end
      end
      S_START: begin
        if (acc_xfer) begin
          gap_d   = 1'b1;
          state_d = S_WAITDONE;
        end
      end
      S_WAITDONE: begin
        if (acc_xfer) begin
          gap_d   = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        cur_layer_d = cur_layer_q + LAYER_W'(1);
        k_d         = '0;
        if (cur_layer_d == num_layers_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    layer_addr      = desc_base_q + 32'(cur_layer_d) * 32'(DESC_STRIDE);
    mem_read_d      = (state_d == S_FETCH) && !gap_d;
    mem_address_d   = layer_addr + 32'({k_d, 2'b00});
    acc_write_d     = ((state_d == S_PROGRAM) || (state_d == S_START)) && !gap_d;
    acc_read_d      = (state_d == S_WAITDONE) && !gap_d;
    acc_address_d   = (state_d == S_PROGRAM) ? 3'(k_d + K_W'(1)) : 3'd0;
    acc_writedata_d = (state_d == S_PROGRAM) ? desc_q[k_d] : 32'h0;
  end

  // State, status and bus output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      k_q           <= '0;
      gap_q         <= 1'b0;
      cur_layer_q   <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      mem_read      <= 1'b0;
      mem_address   <= '0;
      acc_write     <= 1'b0;
      acc_read      <= 1'b0;
      acc_address   <= '0;
      acc_writedata <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      gap_q         <= gap_d;
      cur_layer_q   <= cur_layer_d;
      done_q        <= done_d;
      err_q         <= err_d;
      mem_read      <= mem_read_d;
      mem_address   <= mem_address_d;
      acc_write     <= acc_write_d;
      acc_read      <= acc_read_d;
      acc_address   <= acc_address_d;
      acc_writedata <= acc_writedata_d;
    end
  end

  // CPU-programmed configuration and fetched descriptor words
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      desc_base_q  <= '0;
      num_layers_q <= '0;
      for (int i = 0; i < DESC_WORDS; i++) desc_q[i] <= '0;
    end else begin
      if (!busy && slave_write) begin
        if (slave_address == 3'd1) desc_base_q  <= slave_writedata;
        if (slave_address == 3'd2) num_layers_q <= slave_writedata[LAYER_W-1:0];
      end
      if (desc_wr) desc_q[k_q] <= mem_readdata;
    end
  end

`ifdef SEQ_CYCLE_COUNT_EN
  logic [31:0] cycles_q;
  logic        start_ok;
  assign start_ok  = (state_q == S_IDLE) && start_req;
  assign cycles_rd = cycles_q;

  // Saturating count of busy cycles since the last accepted start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        cycles_q <= '0;
    else if (start_ok)                 cycles_q <= '0;
    else if (busy && (cycles_q != '1)) cycles_q <= cycles_q + 32'd1;
  end
`else
  assign cycles_rd = '0;
`endif

  // Zero-latency CPU register read mux
  always_comb begin
    slave_readdata = '0;
    if (slave_read) begin
      unique case (slave_address)
        3'd0:    slave_readdata = {29'b0, err_q, done_q, busy};
        3'd1:    slave_readdata = desc_base_q;
        3'd2:    slave_readdata = 32'(num_layers_q);
        3'd3:    slave_readdata = 32'(cur_layer_q);
        3'd4:    slave_readdata = cycles_rd;
        default: slave_readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Scoreboard bench for dense_layer_sequencer: memory/accelerator responders,
// expected transfers queued at stimulus time and checked as they complete.
module tb_dense_layer_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        slave_waitrequest;
  logic [2:0]  slave_address;
  logic        slave_read;
  logic [31:0] slave_readdata;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic        mem_waitrequest;
  logic [31:0] mem_address;
  logic        mem_read;
  logic [31:0] mem_readdata;
  logic        acc_waitrequest;
  logic [2:0]  acc_address;
  logic        acc_read;
  logic [31:0] acc_readdata;
  logic        acc_write;
  logic [31:0] acc_writedata;

  dense_layer_sequencer dut (
    .clk(clk), .reset(reset),
    .slave_waitrequest(slave_waitrequest), .slave_address(slave_address),
    .slave_read(slave_read), .slave_readdata(slave_readdata),
    .slave_write(slave_write), .slave_writedata(slave_writedata),
    .mem_waitrequest(mem_waitrequest), .mem_address(mem_address),
    .mem_read(mem_read), .mem_readdata(mem_readdata),
    .acc_waitrequest(acc_waitrequest), .acc_address(acc_address),
    .acc_read(acc_read), .acc_readdata(acc_readdata),
    .acc_write(acc_write), .acc_writedata(acc_writedata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_xfer = 0;
  int n_strobe = 0;
  int mem_stall = 0;
  int acc_wr_stall = 0;
  int acc_rd_stall = 0;
  bit acc_hold = 0;
  int mcnt = 0;
  int acnt = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_mem [$];
  logic [35:0] exp_acc [$];   // {is_read, address, write data}

  // Busy cycles of one unstalled layer: 10 fetch/check + 9 program + 2 start + 2 wait + 1 next
  localparam int ONE_LAYER_CYCLES = 24;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Responders for both masters plus transfer scoreboard, evaluated mid-cycle
  task automatic monitor();
    logic [31:0] e;
    logic [35:0] ea, oa;
    forever begin
      @(negedge clk);
      if (!reset) begin
        mem_waitrequest = 1'b0; acc_waitrequest = 1'b0; mcnt = 0; acnt = 0;
      end else begin
        if (mem_read || acc_write || acc_read) n_strobe++;
        if (mem_read) begin
          if (mcnt < mem_stall) begin mem_waitrequest = 1'b1; mcnt++; end
          else begin mem_waitrequest = 1'b0; mcnt = 0; mem_readdata = mem_word(mem_address); end
        end else begin
          mem_waitrequest = 1'b0; mcnt = 0;
        end
        if (acc_write || acc_read) begin
          if (acc_hold) acc_waitrequest = 1'b1;
          else if (acnt < (acc_read ? acc_rd_stall : acc_wr_stall)) begin acc_waitrequest = 1'b1; acnt++; end
          else begin acc_waitrequest = 1'b0; acnt = 0; end
        end else begin
          acc_waitrequest = 1'b0; acnt = 0;
        end
        if (mem_read && !mem_waitrequest) begin
          n_xfer++;
          n_cmp++;
          if (acc_write || acc_read) begin
            n_bad++; $display("FAIL strobe_overlap mem: acc_write=%b acc_read=%b, required both 0", acc_write, acc_read);
          end
          n_cmp++;
          if (exp_mem.size() == 0) begin
            n_bad++; $display("FAIL mem_unexpected: read at %h, required no read", mem_address);
          end else begin
            e = exp_mem.pop_front();
            if (mem_address !== e) begin
              n_bad++; $display("FAIL mem_addr: got %h, required %h", mem_address, e);
            end
          end
        end
        if ((acc_write || acc_read) && !acc_waitrequest) begin
          n_xfer++;
          oa = {acc_read, acc_address, acc_write ? acc_writedata : 32'h0};
          n_cmp++;
          if ((acc_write && acc_read) || mem_read) begin
            n_bad++; $display("FAIL strobe_overlap acc: w=%b r=%b m=%b, required one strobe", acc_write, acc_read, mem_read);
          end
          n_cmp++;
          if (exp_acc.size() == 0) begin
            n_bad++; $display("FAIL acc_unexpected: got %h, required no transfer", oa);
          end else begin
            ea = exp_acc.pop_front();
            if (oa !== ea) begin
              n_bad++; $display("FAIL acc_xfer: got %h, required %h", oa, ea);
            end
          end
        end
      end
    end
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    slave_address = a; slave_writedata = d; slave_write = 1'b1;
    @(negedge clk);
    slave_write = 1'b0;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [31:0] d);
    slave_address = a; slave_read = 1'b1;
    #1;
    d = slave_readdata;
    slave_read = 1'b0;
  endtask

  task automatic load_desc(input logic [31:0] a, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3, input logic [31:0] w4);
    mem[a] = w0; mem[a + 4] = w1; mem[a + 8] = w2; mem[a + 12] = w3; mem[a + 16] = w4;
  endtask

  task automatic push_layer(input logic [31:0] base, input int layer, input bit run);
    logic [31:0] la;
    la = base + 32'(layer) * 32'd32;
    for (int k = 0; k < 5; k++) exp_mem.push_back(la + 32'(4 * k));
    if (run) begin
      for (int k = 0; k < 5; k++) exp_acc.push_back({1'b0, 3'(k + 1), mem_word(la + 32'(4 * k))});
      exp_acc.push_back({1'b0, 3'd0, 32'h0});
      exp_acc.push_back({1'b1, 3'd0, 32'h0});
    end
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    int i;
    for (i = 0; i < 3000; i++) begin
      cpu_read(3'd0, s);
      if (!s[0]) break;
      @(negedge clk);
    end
    n_cmp++;
    if (i == 3000) begin
      n_bad++; $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", tag, i);
    end
  endtask

  task automatic check_reg(input string tag, input logic [2:0] a, input logic [31:0] req);
    logic [31:0] d;
    cpu_read(a, d);
    n_cmp++;
    if (d !== req) begin
      n_bad++; $display("FAIL %s: reg%0d got %h, required %h", tag, a, d, req);
    end
  endtask

  task automatic check_drained(input string tag);
    n_cmp++;
    if (exp_mem.size() != 0 || exp_acc.size() != 0) begin
      n_bad++; $display("FAIL %s_drained: %0d mem / %0d acc pending, required 0/0", tag, exp_mem.size(), exp_acc.size());
    end
  endtask

  task automatic check_cycles(input string tag, input int busy_cycles);
`ifdef SEQ_CYCLE_COUNT_EN
    check_reg(tag, 3'd4, 32'(busy_cycles));
`else
    check_reg(tag, 3'd4, 32'h0 + 32'(busy_cycles - busy_cycles));
`endif
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({mem_read, acc_write, acc_read, slave_waitrequest} !== 4'b0) begin
      n_bad++; $display("FAIL reset_strobes: got %b, required 0000", {mem_read, acc_write, acc_read, slave_waitrequest});
    end
    reset = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 8; a++) check_reg("reset_regs", 3'(a), 32'h0);
  endtask

  task automatic test_single_layer();
    load_desc(32'h100, 32'h10, 32'h20, 32'h30, 32'h40, 32'd3);
    cpu_write(3'd1, 32'h100);
    cpu_write(3'd2, 32'd1);
    push_layer(32'h100, 0, 1'b1);
    cpu_write(3'd0, 32'h1);
    n_cmp++;
    if (mem_read !== 1'b1 || mem_address !== 32'h100) begin
      n_bad++; $display("FAIL single_first_read: mem_read=%b addr=%h, required 1 / 00000100", mem_read, mem_address);
    end
    check_reg("single_busy", 3'd0, 32'b001);
    wait_idle("single");
    check_reg("single_status", 3'd0, 32'b010);
    check_reg("single_cur", 3'd3, 32'd1);
    check_cycles("single_cycles", ONE_LAYER_CYCLES);
    repeat (5) @(negedge clk);
    check_cycles("single_cycles_hold", ONE_LAYER_CYCLES);
    check_drained("single");
  endtask

  task automatic test_multi_stall();
    for (int l = 0; l < 3; l++)
      load_desc(32'h1000 + 32'(32 * l), 32'(l * 256 + 1), 32'(l * 256 + 2), 32'(l * 256 + 3),
                32'(l * 256 + 4), 32'(5 + l));
    mem_stall = 2; acc_rd_stall = 50;
    cpu_write(3'd1, 32'h1000);
    cpu_write(3'd2, 32'd3);
    for (int l = 0; l < 3; l++) push_layer(32'h1000, l, 1'b1);
    cpu_write(3'd0, 32'h1);
    wait_idle("multi");
    check_reg("multi_status", 3'd0, 32'b010);
    check_reg("multi_cur", 3'd3, 32'd3);
    check_drained("multi");
    mem_stall = 0; acc_rd_stall = 0;
  endtask

  task automatic test_zero_layers();
    int s0;
    cpu_write(3'd2, 32'd0);
    s0 = n_strobe;
    cpu_write(3'd0, 32'h1);
    check_reg("zero_status", 3'd0, 32'b010);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (n_strobe != s0) begin
      n_bad++; $display("FAIL zero_traffic: %0d strobe cycles, required 0", n_strobe - s0);
    end
  endtask

  task automatic test_len_zero();
    load_desc(32'h2000, 32'h11, 32'h22, 32'h33, 32'h44, 32'd8);
    load_desc(32'h2020, 32'h55, 32'h66, 32'h77, 32'h88, 32'd0);
    cpu_write(3'd1, 32'h2000);
    cpu_write(3'd2, 32'd2);
    push_layer(32'h2000, 0, 1'b1);
    push_layer(32'h2000, 1, 1'b0);
    cpu_write(3'd0, 32'h1);
    wait_idle("lenzero");
    check_reg("lenzero_status", 3'd0, 32'b100);
    check_reg("lenzero_cur", 3'd3, 32'd1);
    repeat (5) @(negedge clk);
    check_drained("lenzero");
  endtask

  task automatic test_busy_writes();
    load_desc(32'h3000, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'd9);
    acc_rd_stall = 30;
    cpu_write(3'd1, 32'h3000);
    cpu_write(3'd2, 32'd1);
    push_layer(32'h3000, 0, 1'b1);
    cpu_write(3'd0, 32'h1);
    repeat (10) @(negedge clk);
    cpu_write(3'd1, 32'hDEAD);
    cpu_write(3'd2, 32'd7);
    cpu_write(3'd0, 32'h1);
    check_reg("busy_base", 3'd1, 32'h3000);
    check_reg("busy_num", 3'd2, 32'd1);
    wait_idle("busy");
    check_reg("busy_status", 3'd0, 32'b010);
    repeat (5) @(negedge clk);
    check_drained("busy");
    acc_rd_stall = 0;
  endtask

  task automatic test_reset_mid();
    int i;
    cpu_write(3'd1, 32'h100);
    cpu_write(3'd2, 32'd1);
    acc_hold = 1'b1;
    push_layer(32'h100, 0, 1'b0);
    cpu_write(3'd0, 32'h1);
    for (i = 0; i < 200; i++) begin
      if (acc_write) break;
      @(negedge clk);
    end
    n_cmp++;
    if (i == 200) begin
      n_bad++; $display("FAIL rstmid_program_timeout: acc_write 0 after %0d cycles, required 1", i);
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({acc_write, acc_read, mem_read} !== 3'b000) begin
      n_bad++; $display("FAIL rstmid_strobes: got %b, required 000", {acc_write, acc_read, mem_read});
    end
    for (int a = 0; a < 5; a++) check_reg("rstmid_regs", 3'(a), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    acc_hold = 1'b0;
    check_drained("rstmid");
    cpu_write(3'd1, 32'h100);
    cpu_write(3'd2, 32'd1);
    push_layer(32'h100, 0, 1'b1);
    cpu_write(3'd0, 32'h1);
    wait_idle("rstmid_rerun");
    check_reg("rstmid_status", 3'd0, 32'b010);
    check_cycles("rstmid_cycles", ONE_LAYER_CYCLES);
    check_drained("rstmid_rerun");
  endtask

  initial begin
    reset = 1'b0;
    slave_address = 3'd0; slave_read = 1'b0; slave_write = 1'b0; slave_writedata = 32'h0;
    mem_waitrequest = 1'b0; mem_readdata = 32'h0;
    acc_waitrequest = 1'b0; acc_readdata = 32'h0;
    fork
      monitor();
    join_none
    test_reset();
    test_single_layer();
    test_multi_stall();
    test_zero_layers();
    test_len_zero();
    test_busy_writes();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
